// File: rtl/bcd_scan_display.sv
// Multiplexed N-digit seven-segment display fed by a serial shift-add-3 binary-to-BCD converter.
// Define BCD_LZB_EN to blank leading zeros (ones digit always shown, overflow dashes unaffected).
module bcd_scan_display #(
   parameter int DATA_W   = 8,
   parameter int DIGITS   = 3,
   parameter int PRESCALE = 1024,
   parameter int BLANK    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_n
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0] SEG_DASH = 7'b0000001;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

   state_t            r_state, w_state_nxt;
   logic              w_take, w_last;
   logic [DATA_W-1:0] r_sh;
   logic [BCD_W-1:0]  r_acc, w_acc_adj;
   logic              r_sticky;
   logic [CNT_W-1:0]  r_cnt;
   logic [BCD_W-1:0]  r_disp;
   logic              r_ovf;
   logic [PRE_W-1:0]  r_pre, w_pre_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [DIGITS-1:0] w_show;
   logic [6:0]        r_seg, w_seg_nxt;
   logic [DIGITS-1:0] r_dig_n, w_dig_nxt;

   function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_pattern = 7'b1111110;
         4'd1:    seg_pattern = 7'b0110000;
         4'd2:    seg_pattern = 7'b1101101;
         4'd3:    seg_pattern = 7'b1111001;
         4'd4:    seg_pattern = 7'b0110011;
         4'd5:    seg_pattern = 7'b1011011;
         4'd6:    seg_pattern = 7'b1011111;
         4'd7:    seg_pattern = 7'b1110000;
         4'd8:    seg_pattern = 7'b1111111;
         4'd9:    seg_pattern = 7'b1110011;
         default: seg_pattern = 7'b0000000;
      endcase
   endfunction

   // Converter control
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      load_ready  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            load_ready = 1'b1;
            w_take     = load_valid;
            if (load_valid) w_state_nxt = S_CONV;
         end
         S_CONV:   if (w_last) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign busy = ~load_ready;

   // Shift-add-3 datapath: correct every nibble before the shift so it carries as decimal
   always_comb begin
      for (int k = 0; k < DIGITS; k++) begin
         w_acc_adj[4*k +: 4] = (r_acc[4*k +: 4] > 4'd4) ? r_acc[4*k +: 4] + 4'd3 : r_acc[4*k +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (w_take) begin
         r_sh  <= load_data;
         r_acc <= '0;
      end else if (r_state == S_CONV) begin
         r_sh  <= r_sh << 1;
         r_acc <= {w_acc_adj[BCD_W-2:0], r_sh[DATA_W-1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (w_take) begin
         r_cnt    <= '0;
         r_sticky <= 1'b0;
      end else if (r_state == S_CONV) begin
         r_cnt    <= r_cnt + CNT_W'(1);
         r_sticky <= r_sticky | w_acc_adj[BCD_W-1];
      end
   end

   // Commit stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp <= '0;
         r_ovf  <= 1'b0;
      end else if (r_state == S_COMMIT) begin
         r_disp <= r_acc;
         r_ovf  <= r_sticky;
      end
   end

   assign overflow = r_ovf;

   // Scan: outputs are registered from the post-edge prescaler/index so they stay aligned with them
   always_comb begin
      w_pre_nxt = r_pre + PRE_W'(1);
      w_idx_nxt = r_idx;
      if (r_pre == PRE_W'(PRESCALE - 1)) begin
         w_pre_nxt = '0;
         w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
   end

`ifdef BCD_LZB_EN
   logic w_nz;
   always_comb begin
      w_show = '1;
      w_nz   = 1'b0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         w_nz      = w_nz | (r_disp[4*k +: 4] != 4'd0);
         w_show[k] = w_nz;
      end
   end
`else
   always_comb begin
      w_show = '1;
   end
`endif

   always_comb begin
      w_seg_nxt = 7'b0000000;
      w_dig_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_idx_nxt == IDX_W'(k)) begin
            w_seg_nxt = w_show[k] ? seg_pattern(r_disp[4*k +: 4]) : 7'b0000000;
            if (w_pre_nxt >= PRE_W'(BLANK)) w_dig_nxt[k] = 1'b0;
         end
      end
      if (r_ovf) w_seg_nxt = SEG_DASH;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre   <= '0;
         r_idx   <= '0;
         r_seg   <= 7'b0000000;
         r_dig_n <= '1;
      end else begin
         r_pre   <= w_pre_nxt;
         r_idx   <= w_idx_nxt;
         r_seg   <= w_seg_nxt;
         r_dig_n <= w_dig_nxt;
      end
   end

   assign seg   = r_seg;
   assign dig_n = r_dig_n;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: two instances (3 digits / 2 digits) with short scan prescalers,
// table vectors, handshake and reset sequences, and random loads against a decimal model.
module tb_bcd_scan_display;
`ifdef BCD_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_valid, a_ready, a_busy, a_ovf;
   logic [7:0] a_data;
   logic [6:0] a_seg;
   logic [2:0] a_dig_n;
   logic       b_valid, b_ready, b_busy, b_ovf;
   logic [7:0] b_data;
   logic [6:0] b_seg;
   logic [1:0] b_dig_n;

   bcd_scan_display #(.DATA_W(8), .DIGITS(3), .PRESCALE(4), .BLANK(1)) u_a (
      .clk(clk), .reset(reset), .load_valid(a_valid), .load_data(a_data),
      .load_ready(a_ready), .busy(a_busy), .overflow(a_ovf), .seg(a_seg), .dig_n(a_dig_n));

   bcd_scan_display #(.DATA_W(8), .DIGITS(2), .PRESCALE(6), .BLANK(2)) u_b (
      .clk(clk), .reset(reset), .load_valid(b_valid), .load_data(b_data),
      .load_ready(b_ready), .busy(b_busy), .overflow(b_ovf), .seg(b_seg), .dig_n(b_dig_n));

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc;

   // Edges since the last reset release; the scan position is a pure function of it.
   always @(posedge clk or posedge reset) begin
      if (reset) ncyc <= 0;
      else       ncyc <= ncyc + 1;
   end

   typedef struct {
      int         v;
      bit         ovf;
      logic [6:0] s2, s1, s0;
      logic [1:0] lead;
   } vec_t;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pow10(int k);
      int r = 1;
      for (int i = 0; i < k; i++) r *= 10;
      return r;
   endfunction

   function automatic logic [6:0] pat(int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1110011;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(int v, int digits, int k);
      if (v >= pow10(digits)) return 7'b0000001;
      if (LZB && k > 0 && v < pow10(k)) return 7'b0000000;
      return pat((v / pow10(k)) % 10);
   endfunction

   function automatic int slot_idx(int n, int p, int d);
      return (n / p) % d;
   endfunction

   function automatic int model_dig(int n, int p, int bl, int d);
      int r = (1 << d) - 1;
      if ((n % p) >= bl) r = r & ~(1 << slot_idx(n, p, d));
      return r;
   endfunction

   function automatic logic [6:0] vec_seg(vec_t t, int k);
      if (k == 2) return (LZB && t.lead[1]) ? 7'b0000000 : t.s2;
      if (k == 1) return (LZB && t.lead[0]) ? 7'b0000000 : t.s1;
      return t.s0;
   endfunction

   function automatic int prm_p(int inst);  return (inst == 0) ? 4 : 6; endfunction
   function automatic int prm_d(int inst);  return (inst == 0) ? 3 : 2; endfunction
   function automatic int prm_bl(int inst); return (inst == 0) ? 1 : 2; endfunction

   task automatic check_scan(int inst, logic [6:0] exp_seg);
      int n = ncyc;
      if (inst == 0) begin
         check("A seg", 32'(a_seg), 32'(exp_seg));
         check("A dig_n", 32'(a_dig_n), model_dig(n, 4, 1, 3));
      end else begin
         check("B seg", 32'(b_seg), 32'(exp_seg));
         check("B dig_n", 32'(b_dig_n), model_dig(n, 6, 2, 2));
      end
   endtask

   task automatic check_outputs(int inst, int v);
      int n = ncyc;
      logic [6:0] es;
      es = (n == 0) ? 7'b0000000 : model_seg(v, prm_d(inst), slot_idx(n, prm_p(inst), prm_d(inst)));
      check_scan(inst, es);
   endtask

   task automatic check_frame(int inst, int v);
      for (int c = 0; c < prm_p(inst) * prm_d(inst); c++) begin
         @(negedge clk);
         check_outputs(inst, v);
      end
   endtask

   // Returns at the first falling edge where load_ready is back; low = falling edges seen busy.
   task automatic load(int inst, int v, output int low);
      int guard = 0;
      @(negedge clk);
      while (!((inst == 0) ? a_ready : b_ready) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("ready before load", 32'((inst == 0) ? a_ready : b_ready), 32'd1);
      if (inst == 0) begin a_valid = 1'b1; a_data = 8'(v); end
      else           begin b_valid = 1'b1; b_data = 8'(v); end
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("busy during conversion", 32'((inst == 0) ? a_busy : b_busy), 32'd1);
      low = 0;
      while (!((inst == 0) ? a_ready : b_ready) && low < 100) begin
         low++;
         @(negedge clk);
      end
      check("busy after conversion", 32'((inst == 0) ? a_busy : b_busy), 32'd0);
   endtask

   task automatic apply_vec(int inst, vec_t t);
      int low, p, d;
      p = prm_p(inst);
      d = prm_d(inst);
      load(inst, t.v, low);
      check("ready-low cycles", low, 9);
      check("overflow", 32'((inst == 0) ? a_ovf : b_ovf), 32'(t.ovf));
      for (int c = 0; c < p * d; c++) begin
         @(negedge clk);
         check_scan(inst, vec_seg(t, slot_idx(ncyc, p, d)));
      end
   endtask

   task automatic check_reset_values();
      check("rst A seg", 32'(a_seg), 32'd0);
      check("rst A dig_n", 32'(a_dig_n), 32'h7);
      check("rst A ready", 32'(a_ready), 32'd1);
      check("rst A busy", 32'(a_busy), 32'd0);
      check("rst A ovf", 32'(a_ovf), 32'd0);
      check("rst B dig_n", 32'(b_dig_n), 32'h3);
      check("rst B ovf", 32'(b_ovf), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va[7];
      vec_t vb[7];
      logic [2:0] scan_seq[12];
      int low, guard, v;

      va[0] = '{255, 1'b0, 7'b1101101, 7'b1011011, 7'b1011011, 2'b00};
      va[1] = '{0,   1'b0, 7'b1111110, 7'b1111110, 7'b1111110, 2'b11};
      va[2] = '{7,   1'b0, 7'b1111110, 7'b1111110, 7'b1110000, 2'b11};
      va[3] = '{42,  1'b0, 7'b1111110, 7'b0110011, 7'b1101101, 2'b10};
      va[4] = '{100, 1'b0, 7'b0110000, 7'b1111110, 7'b1111110, 2'b00};
      va[5] = '{209, 1'b0, 7'b1101101, 7'b1111110, 7'b1110011, 2'b00};
      va[6] = '{68,  1'b0, 7'b1111110, 7'b1011111, 7'b1111111, 2'b10};

      vb[0] = '{100, 1'b1, 7'b0, 7'b0000001, 7'b0000001, 2'b00};
      vb[1] = '{99,  1'b0, 7'b0, 7'b1110011, 7'b1110011, 2'b00};
      vb[2] = '{0,   1'b0, 7'b0, 7'b1111110, 7'b1111110, 2'b01};
      vb[3] = '{5,   1'b0, 7'b0, 7'b1111110, 7'b1011011, 2'b01};
      vb[4] = '{42,  1'b0, 7'b0, 7'b0110011, 7'b1101101, 2'b00};
      vb[5] = '{255, 1'b1, 7'b0, 7'b0000001, 7'b0000001, 2'b00};
      vb[6] = '{10,  1'b0, 7'b0, 7'b0110000, 7'b1111110, 2'b00};

      scan_seq = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b101,
                   3'b101, 3'b101, 3'b111, 3'b011, 3'b011, 3'b011};

      reset = 1'b1;
      a_valid = 1'b0; a_data = '0;
      b_valid = 1'b0; b_data = '0;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset = 1'b0;

      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         check("A scan sequence", 32'(a_dig_n), 32'(scan_seq[c]));
      end
      check_frame(0, 0);
      check_frame(1, 0);

      foreach (va[i]) apply_vec(0, va[i]);
      foreach (vb[i]) apply_vec(1, vb[i]);

      // Producer holds valid; data changes while busy must not be captured.
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = 8'd42;
      @(posedge clk);
      @(negedge clk);
      check("HS busy", 32'(a_busy), 32'd1);
      a_data = 8'd7;
      guard = 0;
      while (!a_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("HS first conversion length", guard, 9);
      @(negedge clk);
      check("HS 7 accepted at first edge", 32'(a_ready), 32'd0);
      a_valid = 1'b0;
      for (int c = 0; c < 9; c++) begin
         check_outputs(0, 42);
         @(negedge clk);
      end
      check("HS second conversion done", 32'(a_ready), 32'd1);
      check_frame(0, 7);

      for (int it = 0; it < 25; it++) begin
         v = int'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         load(0, v, low);
         check("rand A ready-low", low, 9);
         check("rand A overflow", 32'(a_ovf), 32'(v >= 1000));
         check_frame(0, v);
      end
      for (int it = 0; it < 25; it++) begin
         v = int'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         load(1, v, low);
         check("rand B ready-low", low, 9);
         check("rand B overflow", 32'(b_ovf), 32'(v >= 100));
         check_frame(1, v);
      end

      // Reset in the middle of a conversion, with B showing an overflow beforehand.
      load(1, 255, low);
      check("pre-reset B overflow", 32'(b_ovf), 32'd1);
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = 8'd200;
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("post-reset A ready", 32'(a_ready), 32'd1);
      check_frame(0, 0);
      check("post-reset A ovf", 32'(a_ovf), 32'd0);
      check_frame(1, 0);
      load(0, 5, low);
      check("post-reset load ready-low", low, 9);
      check_frame(0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Parametrised multiplexed seven-segment display engine that replaces the fixed 8-bit/3-digit converter and scanner next to the CPU output register. Holds a value accepted over a valid/ready handshake and converts it to BCD with a serial shift-add-3 FSM, one bit per clock. Drives an N-digit common-cathode display with a prescaled scan, anti-ghost blanking and overflow indication. Sits between the CPU `out` register (or any producer in the `clk` domain) and the board pins.

## Interface
- `DATA_W`, 8: binary input width, 1..32.
- `DIGITS`, 3: number of display digits, 1..10.
- `PRESCALE`, 1024: `clk` cycles per digit slot, ≥ `BLANK`+1.
- `BLANK`, 2: cycles at the start of each slot with all digits off, ≥ 0.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `load_valid`  in  1  producer has a value.
- `load_data`  in  `DATA_W`  unsigned value to display.
- `load_ready`  out  1  converter idle; a transfer occurs when `load_valid && load_ready` at a `clk` edge.
- `busy`  out  1  conversion in progress; equals `~load_ready`.
- `overflow`  out  1  the last committed value was ≥ 10^`DIGITS`.
- `seg`  out  7  segments, active-high; bit 6 = A … bit 0 = G.
- `dig_n`  out  `DIGITS`  active-low digit enables, one-hot low; bit 0 = ones digit.

## Operation
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: `load_ready`=1. On a transfer, capture `load_data` into the shift register, clear the BCD accumulator (4·`DIGITS` bits) and the overflow sticky bit, clear the bit counter, and go to CONV.
  - CONV: each cycle, add 3 to every nibble > 4, then shift left one bit with the shift-register MSB entering bit 0. If the bit shifted out of the accumulator's top is 1, set the overflow sticky bit. Leave after `DATA_W` shifts.
  - COMMIT: copy the accumulator and the sticky bit into the display register and `overflow`, then return to IDLE.
- `load_valid` asserted outside IDLE is ignored and nothing is captured. The producer holds the value until `load_ready`.
- Display register and `overflow` change only in COMMIT.
- If `overflow`=1, every digit shows a dash (7'b0000001).
- Digit patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011
  - any other nibble = 0000000.
- Scan:
  - The prescaler counts 0..`PRESCALE`-1. On wrap, the digit index advances 0→1→…→`DIGITS`-1→0.
  - `seg` and `dig_n` are registered from the index, the prescaler and the display register, so both change on the same edge.
  - While prescaler < `BLANK`, `dig_n` is all ones and `seg` already holds the new digit's pattern.

## Timing
- Reset values: `seg`=0, `dig_n`=all ones, `load_ready`=1, `busy`=0, `overflow`=0.
- Reset also clears the display register, the prescaler, the digit index (0) and the FSM (IDLE).
- Latency: transfer at edge T. CONV occupies edges T+1..T+`DATA_W`. COMMIT occurs at edge T+`DATA_W`+1, with `load_ready`=1 after it.
- Throughput is one value per `DATA_W`+2 cycles.
- New digits appear on `seg` one edge after COMMIT, within the current slot.
- Frame period is `DIGITS`·`PRESCALE` cycles. Each digit is lit for `PRESCALE`-`BLANK` cycles per frame.
- Reset mid-conversion aborts the conversion. The old value is lost and the display shows 0 after release.
- Value 0 displays "0…0" (see the Configuration section for leading-zero blanking). The maximum `DATA_W` value with no overflow is 10^`DIGITS`-1.

## Configuration
- `BCD_LZB_EN` defined: leading-zero blanking. Every digit above the most-significant non-zero digit shows 7'b0000000, and the ones digit is always shown. Dashes on overflow are unaffected.
- `BCD_LZB_EN` undefined: every digit is always shown, including leading zeros.

## Test plan
- Reset, defaults: assert `reset` mid-frame and release → `seg`=0, `dig_n`=3'b111, `load_ready`=1. After `BLANK` cycles, `dig_n`=3'b110 and `seg`=1111110.
- Conversion of 255 (DATA_W=8, DIGITS=3): `load_ready` is low for exactly 9 cycles. The hundreds/tens/ones slots show 1101101 / 1011011 / 1011011, and `overflow`=0.
- Overflow (DIGITS=2): load 100 → `overflow`=1 and both digits show 0000001. A following load of 99 → `overflow`=0 and the display shows 1110011 twice.
- Handshake: hold `load_valid`=1 with 42, then switch `load_data` to 7 while `busy` → 42 is displayed. The value 7 is accepted only at the first edge after `load_ready` returns. The display then shows 0,0,7, or blank,blank,7 with `BCD_LZB_EN`.
- Scan with PRESCALE=4, BLANK=1, DIGITS=3: the `dig_n` per-cycle sequence is 111,110,110,110,111,101,101,101,111,011,011,011, repeating.
- Reset mid-conversion: reset 3 cycles after loading 200 → display shows 0 and `overflow`=0. After release, `load_ready`=1 and a fresh load of 5 displays correctly.
